code_decoder: RTL and testbench
===============================

// Module: code_decoder
// PURPOSE
//  Receive side of the 8-to-3 priority-encoder code. Takes the 4-bit active-low code yn[3:0]
//  (yn[3]=0 means a valid input is present; yn[2:0] = ~index) and turns it back into an
//  active-low one-hot output out_n[7:0]. It synchronises the code, qualifies it for stability,
//  latches the result and holds it for a programmable time after the code goes idle.
//  Sits between the encoder bus and the LED/select drivers.
// PARAMETERS
//  STABLE_CYCLES  4  identical consecutive synchronised samples required to accept a code (>=2)
//  HOLD_CYCLES    8  cycles the last accepted code is held after yn returns idle (>=1)
//  CNT_W          8  width of the qualify and hold counters; must cover both parameters
// PORTS
//  clk       in   1  single system clock, rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  en        in   1  decoder enable; when low, outputs are forced idle
//  yn        in   4  encoder code, active low; 4'b1111 = idle
//  out_n     out  8  decoded one-hot output, active low
//  idx       out  3  latched decoded index
//  valid     out  1  high while an accepted code is driven
//  new_code  out  1  one-cycle pulse when a newly accepted index is latched
// BEHAVIOUR
//  - Reset: async assert. Sync flops = 4'b1111, state = IDLE, counters = 0.
//    Outputs: out_n = 8'hFF, idx = 0, valid = 0, new_code = 0. All outputs are registered.
//  - Sync: yn passes through 2 flops -> ys. cv = ~ys[3], ci = ~ys[2:0].
//  - FSM states: IDLE, QUAL, ACTIVE, HOLD.
//  - IDLE: outputs idle. If en && cv: cand <= ci, qcnt <= 1, go to QUAL.
//  - QUAL: previously latched outputs stay unchanged.
//    - If !cv: go to IDLE when nothing is latched (valid=0), else go to HOLD.
//    - If cv && ci != cand: cand <= ci, qcnt <= 1.
//    - If cv && ci == cand: qcnt++. When qcnt+1 == STABLE_CYCLES, go to ACTIVE.
//      On that edge: out_n <= ~(8'b1 << cand), idx <= cand, valid <= 1,
//      new_code <= (cand != idx || !valid).
//  - ACTIVE: stay while cv && ci == idx.
//    - cv && ci != idx: cand <= ci, go to QUAL; old outputs held until the new code qualifies.
//    - !cv: hcnt <= 1, go to HOLD.
//  - HOLD: outputs held.
//    - cv && ci == idx: go to ACTIVE with no new_code pulse.
//    - cv && ci != idx: go to QUAL.
//    - !cv: hcnt++. When hcnt == HOLD_CYCLES, go to IDLE and drive outputs idle on that edge.
//  - new_code is high for exactly one cycle and never in consecutive cycles.
//  - Latency: with yn changed before edge 1 and then held, the accepted outputs and new_code
//    update on edge 2+STABLE_CYCLES (edge 6 at default).
//  - en low: from any state, the next edge goes to IDLE with idle outputs and cleared counters.
//    The synchroniser keeps running. When en rises, qualification restarts from IDLE.
//  - Simultaneous events: en low has priority over every transition. A code change on the edge
//    where qcnt would complete restarts qualification and does not accept the code.
//  - Counters saturate and never wrap. A valid=0, idx=0 reset state followed by acceptance of
//    index 0 still pulses new_code.
//  - Reset mid-operation (any state) returns to the reset values immediately, asynchronously.
// STRUCTURE
//  - Shared include code_dec_defs.vh: state encodings (IDLE=2'd0, QUAL=2'd1, ACTIVE=2'd2,
//    HOLD=2'd3), YN_IDLE = 4'b1111, OUT_IDLE = 8'hFF.
//  - Sub-module sync2 (parameterised width, 2-flop, async active-low reset to a parameter value)
//    for yn. FSM, counters and output registers stay in code_decoder.
// TESTING
//  1. Reset with yn=4'b1111 -> out_n=8'hFF, valid=0, new_code=0. After release nothing changes
//     for 20 cycles.
//  2. yn=4'b0010 held -> on edge 6: out_n=8'b1101_1111, idx=5, valid=1, new_code high for one
//     cycle only.
//  3. From ACTIVE idx=5, yn=4'b0000 for 3 cycles then back to 0010 -> outputs stay at idx 5,
//     no new_code.
//  4. From ACTIVE idx=5, yn=1111 for 5 cycles then 0010 -> returns to ACTIVE, out_n unchanged,
//     no new_code. Then yn=1111 held -> out_n=8'hFF, valid=0 on edge 2+8 after the change.
//  5. From ACTIVE idx=5, yn=4'b0111 held -> idx 5 held for 5 edges, then out_n=8'b1111_1110,
//     idx=0, new_code pulse.
//  6. en low during ACTIVE -> next edge out_n=8'hFF, valid=0. rst_n low mid-QUAL -> outputs
//     idle immediately (asynchronously); after release and en high, code re-qualifies in full
//     STABLE_CYCLES.

Source files
------------

// File: rtl/code_decoder_pkg.sv
// Shared definitions for the code decoder: FSM state encoding, idle code
// values and the one-hot decode helper.
package code_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] YN_IDLE  = 4'b1111;
  localparam logic [7:0] OUT_IDLE = 8'hFF;

  // Active-low one-hot pattern for a 3-bit index.
  function automatic logic [7:0] onehot_n(input logic [2:0] index);
    return ~(8'b0000_0001 << index);
  endfunction

endpackage

// File: rtl/code_decoder_sync2.sv
// Two-flop synchroniser, parameterised width, asynchronous active-low reset
// to a programmable value.
module sync2 #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      // Two-stage capture of each bit; reset to the bit's idle value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg[gi] <= RST_VAL[gi];
          sync_reg[gi] <= RST_VAL[gi];
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/code_decoder.sv
// Receive-side decoder for the active-low priority-encoder code. Synchronises
// the code, accepts it after STABLE_CYCLES identical samples, drives an
// active-low one-hot output and holds it for HOLD_CYCLES after the bus idles.
module code_decoder
  import code_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] yn,
  output logic [7:0] out_n,
  output logic [2:0] idx,
  output logic       valid,
  output logic       new_code
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYCLES);

  logic [3:0] ys;
  logic       cv;
  logic [2:0] ci;

  state_t           state_reg, state_next;
  logic [2:0]       cand_reg, cand_next;
  logic [CNT_W-1:0] qcnt_reg, qcnt_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [7:0]       out_n_reg, out_n_next;
  logic [2:0]       idx_reg, idx_next;
  logic             valid_reg, valid_next;
  logic             new_code_reg, new_code_next;
  logic [CNT_W-1:0] qcnt_inc, hcnt_inc;

  sync2 #(.W(4), .RST_VAL(YN_IDLE)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (yn),
    .q     (ys)
  );

  assign cv = ~ys[3];
  assign ci = ~ys[2:0];

  // Saturating increments so long runs never wrap back below the limits.
  assign qcnt_inc = (qcnt_reg == CNT_MAX) ? qcnt_reg : qcnt_reg + CNT_ONE;
  assign hcnt_inc = (hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + CNT_ONE;

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cand_reg     <= '0;
      qcnt_reg     <= '0;
      hcnt_reg     <= '0;
      out_n_reg    <= OUT_IDLE;
      idx_reg      <= '0;
      valid_reg    <= 1'b0;
      new_code_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cand_reg     <= cand_next;
      qcnt_reg     <= qcnt_next;
      hcnt_reg     <= hcnt_next;
      out_n_reg    <= out_n_next;
      idx_reg      <= idx_next;
      valid_reg    <= valid_next;
      new_code_reg <= new_code_next;
    end
  end

  // Next-state and output logic; disable overrides every transition.
  always_comb begin
    state_next    = state_reg;
    cand_next     = cand_reg;
    qcnt_next     = qcnt_reg;
    hcnt_next     = hcnt_reg;
    out_n_next    = out_n_reg;
    idx_next      = idx_reg;
    valid_next    = valid_reg;
    new_code_next = 1'b0;

    if (!en) begin
      state_next = ST_IDLE;
      cand_next  = '0;
      qcnt_next  = '0;
      hcnt_next  = '0;
      out_n_next = OUT_IDLE;
      idx_next   = '0;
      valid_next = 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (cv) begin
            cand_next  = ci;
            qcnt_next  = CNT_ONE;
            state_next = ST_QUAL;
          end
        end

        ST_QUAL: begin
          if (!cv) begin
            qcnt_next = '0;
            if (valid_reg) begin
              hcnt_next  = CNT_ONE;
              state_next = ST_HOLD;
            end else begin
              state_next = ST_IDLE;
            end
          end else if (ci != cand_reg) begin
            // A changed code restarts qualification, even on the completing edge.
            cand_next = ci;
            qcnt_next = CNT_ONE;
          end else begin
            qcnt_next = qcnt_inc;
            if (qcnt_inc >= STABLE_LIM) begin
              qcnt_next     = '0;
              state_next    = ST_ACTIVE;
              out_n_next    = onehot_n(cand_reg);
              idx_next      = cand_reg;
              valid_next    = 1'b1;
              new_code_next = (cand_reg != idx_reg) || !valid_reg;
            end
          end
        end

        ST_ACTIVE: begin
          if (!cv) begin
            hcnt_next  = CNT_ONE;
            state_next = ST_HOLD;
          end else if (ci != idx_reg) begin
            cand_next  = ci;
            qcnt_next  = CNT_ONE;
            state_next = ST_QUAL;
          end
        end

        ST_HOLD: begin
          if (cv && (ci == idx_reg)) begin
            hcnt_next  = '0;
            state_next = ST_ACTIVE;
          end else if (cv) begin
            hcnt_next  = '0;
            cand_next  = ci;
            qcnt_next  = CNT_ONE;
            state_next = ST_QUAL;
          end else begin
            hcnt_next = hcnt_inc;
            if (hcnt_inc >= HOLD_LIM) begin
              hcnt_next  = '0;
              state_next = ST_IDLE;
              out_n_next = OUT_IDLE;
              idx_next   = '0;
              valid_next = 1'b0;
            end
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign out_n    = out_n_reg;
  assign idx      = idx_reg;
  assign valid    = valid_reg;
  assign new_code = new_code_reg;

endmodule

// File: tb/tb_code_decoder.sv
// Bench for code_decoder: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_code_decoder;

  localparam int STABLE = 4;
  localparam int HOLD   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] yn = 4'b1111;
  logic [7:0] out_n;
  logic [2:0] idx;
  logic       valid;
  logic       new_code;

  int total = 0;
  int bad = 0;
  int nc_seen = 0;
  bit cmp_on = 1'b0;

  code_decoder #(.STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .yn       (yn),
    .out_n    (out_n),
    .idx      (idx),
    .valid    (valid),
    .new_code (new_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // The model thinks in terms of runs: how long the current candidate code has
  // been seen (run_len > 0 means still qualifying) and how long the bus has
  // been idle while something is latched (idle_run > 0 means holding).
  logic [3:0] p0, p1;
  bit         m_valid;
  logic [2:0] m_idx;
  logic [7:0] m_out;
  bit         m_nc;
  logic [2:0] cand;
  int         run_len, idle_run;

  task automatic model_clear();
    m_valid = 0; m_idx = 0; m_out = 8'hFF; m_nc = 0;
    cand = 0; run_len = 0; idle_run = 0;
  endtask

  initial begin
    p0 = 4'hF; p1 = 4'hF;
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        p0 = 4'hF; p1 = 4'hF;
        model_clear();
      end else begin
        bit         code_present;
        logic [2:0] code;
        bit         pulse;
        code_present = !p1[3];
        code = ~p1[2:0];
        pulse = 0;
        if (!en) begin
          model_clear();
        end else if (run_len > 0) begin
          if (!code_present) begin
            run_len = 0;
            if (m_valid) idle_run = 1;
          end else if (code != cand) begin
            cand = code; run_len = 1;
          end else begin
            run_len++;
            if (run_len >= STABLE) begin
              pulse = (code != m_idx) || !m_valid;
              m_valid = 1; m_idx = code; m_out = ~(8'd1 << code);
              run_len = 0;
            end
          end
        end else if (idle_run > 0) begin
          if (code_present && code == m_idx) begin
            idle_run = 0;
          end else if (code_present) begin
            idle_run = 0; cand = code; run_len = 1;
          end else begin
            idle_run++;
            if (idle_run >= HOLD) begin
              idle_run = 0; m_valid = 0; m_idx = 0; m_out = 8'hFF;
            end
          end
        end else if (m_valid) begin
          if (!code_present) idle_run = 1;
          else if (code != m_idx) begin
            cand = code; run_len = 1;
          end
        end else if (code_present) begin
          cand = code; run_len = 1;
        end
        m_nc = pulse;
        p1 = p0;
        p0 = yn;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("out_n", 32'(out_n), 32'(m_out));
        chk("idx", 32'(idx), 32'(m_idx));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("new_code", 32'(new_code), 32'(m_nc));
      end
      if (new_code === 1'b1) nc_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nc0;
    logic [3:0] pick;
    int len;

    // 1. reset
    rst_n = 1'b0; en = 1'b1; yn = 4'b1111;
    edges(3);
    cmp_on = 1'b1;
    chk("rst_out_n", 32'(out_n), 32'hFF);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_new_code", 32'(new_code), 32'h0);
    rst_n = 1'b1;
    nc0 = nc_seen;
    edges(20);
    chk("idle20_out_n", 32'(out_n), 32'hFF);
    chk("idle20_pulses", 32'(nc_seen - nc0), 32'h0);

    // 2. accept index 5 on edge 6
    yn = 4'b0010;
    edges(5);
    chk("t2_edge5_valid", 32'(valid), 32'h0);
    edges(1);
    chk("t2_out_n", 32'(out_n), 32'hDF);
    chk("t2_idx", 32'(idx), 32'h5);
    chk("t2_valid", 32'(valid), 32'h1);
    chk("t2_new_code", 32'(new_code), 32'h1);
    edges(1);
    chk("t2_new_code_once", 32'(new_code), 32'h0);

    // 3. short glitch to index 7 then back: no change, no pulse
    nc0 = nc_seen;
    yn = 4'b0000;
    edges(3);
    yn = 4'b0010;
    edges(10);
    chk("t3_out_n", 32'(out_n), 32'hDF);
    chk("t3_idx", 32'(idx), 32'h5);
    chk("t3_pulses", 32'(nc_seen - nc0), 32'h0);

    // 4. short idle then same code: back to active; then idle times out
    nc0 = nc_seen;
    yn = 4'b1111;
    edges(5);
    yn = 4'b0010;
    edges(6);
    chk("t4_out_n", 32'(out_n), 32'hDF);
    chk("t4_pulses", 32'(nc_seen - nc0), 32'h0);
    yn = 4'b1111;
    edges(9);
    chk("t4_hold_valid", 32'(valid), 32'h1);
    edges(1);
    chk("t4_timeout_out_n", 32'(out_n), 32'hFF);
    chk("t4_timeout_valid", 32'(valid), 32'h0);

    // 5. switch from index 5 to index 0
    yn = 4'b0010;
    edges(8);
    yn = 4'b0111;
    edges(5);
    chk("t5_held_idx", 32'(idx), 32'h5);
    edges(1);
    chk("t5_out_n", 32'(out_n), 32'hFE);
    chk("t5_idx", 32'(idx), 32'h0);
    chk("t5_new_code", 32'(new_code), 32'h1);

    // 6. enable low forces idle; index 0 after clear still pulses
    en = 1'b0;
    edges(1);
    chk("t6_en_out_n", 32'(out_n), 32'hFF);
    chk("t6_en_valid", 32'(valid), 32'h0);
    en = 1'b1;
    edges(3);
    chk("t6_requal_valid", 32'(valid), 32'h0);
    edges(1);
    chk("t6_idx0_out_n", 32'(out_n), 32'hFE);
    chk("t6_idx0_new_code", 32'(new_code), 32'h1);

    // asynchronous reset mid-qualification
    yn = 4'b0010;
    edges(4);
    chk("t6_qual_held", 32'(out_n), 32'hFE);
    rst_n = 1'b0;
    #2;
    chk("t6_async_out_n", 32'(out_n), 32'hFF);
    chk("t6_async_valid", 32'(valid), 32'h0);
    edges(1);
    rst_n = 1'b1;
    edges(5);
    chk("t6_post_rst_valid", 32'(valid), 32'h0);
    edges(1);
    chk("t6_post_rst_out_n", 32'(out_n), 32'hDF);
    chk("t6_post_rst_new_code", 32'(new_code), 32'h1);

    // randomized phase: codes held for random lengths, occasional disable
    for (int s = 0; s < 350; s++) begin
      case ($urandom_range(0, 4))
        0:       pick = 4'b1111;
        1:       pick = 4'b0010;
        2:       pick = 4'b0111;
        default: pick = 4'($urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        yn = pick;
        en = ($urandom_range(0, 24) != 0);
        edges(1);
      end
    end
    en = 1'b1;
    yn = 4'b1111;
    edges(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
